// File: rtl/quiz_round_controller.sv
// Quiz round controller: synchronises remote buttons, arbitrates the first
// press, judges it against the question table, keeps scores and declares a winner.
module quiz_round_controller #(
  parameter int NUM_PLAYERS   = 2,
  parameter int NUM_CHOICES   = 4,
  parameter int WIN_SCORE     = 5,
  parameter int NUM_QUESTIONS = 10,
  parameter int BEEP_CYCLES   = 1000,
  parameter int SCORE_W       = 4,
  parameter int QIDX_W        = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_PLAYERS*NUM_CHOICES-1:0] btn_n,
  input  logic [2:0]                     ans_choice,
  output logic [QIDX_W-1:0]              question_idx,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [NUM_PLAYERS-1:0]         lockout,
  output logic                           correct_pls,
  output logic                           beep,
  output logic                           game_over,
  output logic [NUM_PLAYERS-1:0]         winner
);

  localparam int NB = NUM_PLAYERS * NUM_CHOICES;
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int TW = $clog2(BEEP_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, ASK, JUDGE, BEEP, NEXT, OVER
  } state_t;

  state_t state, state_nx;

  logic [NB-1:0]      sync1, sync2, hist;
  logic [NB-1:0]      press;
  logic [SCORE_W-1:0] score_q [NUM_PLAYERS];
  logic [PW-1:0]      pl_q;
  logic [2:0]         ch_q;
  logic [TW-1:0]      timer_q;

  logic               found;
  logic [PW-1:0]      sel_p;
  logic [2:0]         sel_c;
  logic               is_correct;
  logic               win_any;
  logic               all_locked;

  assign press      = hist & ~sync2;
  assign is_correct = (ch_q == ans_choice);
  assign all_locked = &(lockout | (NUM_PLAYERS'(1) << pl_q));

  // Pick the lowest unlocked player, then that player's lowest choice
  always_comb begin
    found = 1'b0;
    sel_p = '0;
    sel_c = '0;
    for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
      for (int c = NUM_CHOICES - 1; c >= 0; c--) begin
        if (!lockout[p] && press[p*NUM_CHOICES+c]) begin
          found = 1'b1;
          sel_p = PW'(p);
          sel_c = 3'(c + 1);
        end
      end
    end
  end

  // Flatten scores and detect a player sitting at the winning score
  always_comb begin
    scores  = '0;
    win_any = 1'b0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      scores[p*SCORE_W +: SCORE_W] = score_q[p];
      if (score_q[p] == SCORE_W'(WIN_SCORE)) win_any = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ASK;
      ASK: begin
        if (ans_choice == 3'd0) state_nx = NEXT;
        else if (found)         state_nx = JUDGE;
      end
      JUDGE: begin
        if (is_correct)      state_nx = BEEP;
        else if (all_locked) state_nx = NEXT;
        else                 state_nx = ASK;
      end
      BEEP: begin
        if (timer_q == TW'(1)) state_nx = win_any ? OVER : NEXT;
      end
      NEXT:    state_nx = ASK;
      OVER:    if (start) state_nx = ASK;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    correct_pls = (state == JUDGE) && is_correct;
    beep        = (state == BEEP);
    game_over   = (state == OVER);
    winner      = '0;
    if (state == OVER) begin
      for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
        if (score_q[p] == SCORE_W'(WIN_SCORE)) winner = NUM_PLAYERS'(1) << p;
      end
    end
  end

  // Button synchroniser, press history, scores, lockout, index and beep timer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1        <= '1;
      sync2        <= '1;
      hist         <= '1;
      pl_q         <= '0;
      ch_q         <= '0;
      timer_q      <= '0;
      lockout      <= '0;
      question_idx <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) score_q[p] <= '0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      hist  <= sync2;
      case (state)
        IDLE, OVER: begin
          if (start) begin
            lockout      <= '0;
            question_idx <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) score_q[p] <= '0;
          end
        end
        ASK: begin
          if (ans_choice != 3'd0 && found) begin
            pl_q <= sel_p;
            ch_q <= sel_c;
          end
        end
        JUDGE: begin
          if (is_correct) begin
            if (score_q[pl_q] < SCORE_W'(WIN_SCORE))
              score_q[pl_q] <= score_q[pl_q] + 1'b1;
            timer_q <= TW'(BEEP_CYCLES);
          end else begin
            lockout[pl_q] <= 1'b1;
          end
        end
        BEEP: timer_q <= timer_q - 1'b1;
        NEXT: begin
          lockout <= '0;
          if (question_idx == QIDX_W'(NUM_QUESTIONS - 1))
            question_idx <= '0;
          else
            question_idx <= question_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
